// File: rtl/reorder_buffer_mc.sv
// rtl/reorder_buffer_mc.sv - multi-port writeback, dual-commit reorder buffer with precise exceptions
module reorder_buffer_mc #(
    parameter int N              = 8,
    parameter int WORD_SIZE      = 32,
    parameter int REG_INDEX_SIZE = 5,
    parameter int NUM_WB         = 3,
    parameter int COMMIT_WIDTH   = 2,
    localparam int IW            = $clog2(N)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alloc_valid,
    input  logic                                   alloc_is_store,
    input  logic                                   alloc_exception,
    input  logic [REG_INDEX_SIZE-1:0]              alloc_rd,
    input  logic [WORD_SIZE-1:0]                   alloc_pc,
    output logic                                   alloc_ready,
    output logic [IW-1:0]                          alloc_rob_id,
    input  logic [NUM_WB-1:0]                      wb_valid,
    input  logic [NUM_WB-1:0]                      wb_exception,
    input  logic [NUM_WB*IW-1:0]                   wb_rob_id,
    input  logic [NUM_WB*WORD_SIZE-1:0]            wb_value,
    input  logic [NUM_WB*WORD_SIZE-1:0]            wb_vaddr,
    input  logic [IW-1:0]                          rs1_rob_id,
    input  logic [IW-1:0]                          rs2_rob_id,
    output logic [WORD_SIZE-1:0]                   bypass_s1,
    output logic [WORD_SIZE-1:0]                   bypass_s2,
    output logic                                   bypass_s1_valid,
    output logic                                   bypass_s2_valid,
    output logic [COMMIT_WIDTH-1:0]                commit_valid,
    output logic [COMMIT_WIDTH-1:0]                commit_is_store,
    output logic [COMMIT_WIDTH*REG_INDEX_SIZE-1:0] commit_rd,
    output logic [COMMIT_WIDTH*WORD_SIZE-1:0]      commit_value,
    output logic [COMMIT_WIDTH*IW-1:0]             commit_rob_id,
    input  logic                                   sb_ready,
    output logic                                   exception,
    output logic [WORD_SIZE-1:0]                   ex_pc,
    output logic [WORD_SIZE-1:0]                   ex_vaddr,
    output logic [IW-1:0]                          ex_rob_id,
    output logic [IW:0]                            count
);

    localparam logic [IW:0] N_CNT = (IW+1)'(N);

    logic [N-1:0]              e_valid;
    logic [N-1:0]              e_ready;
    logic [N-1:0]              e_exc;
    logic [N-1:0]              e_store;
    logic [REG_INDEX_SIZE-1:0] e_rd    [N];
    logic [WORD_SIZE-1:0]      e_value [N];
    logic [WORD_SIZE-1:0]      e_pc    [N];
    logic [WORD_SIZE-1:0]      e_vaddr [N];

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW-1:0] slot_id [COMMIT_WIDTH];
    logic [IW:0]   n_commit;
    logic          alloc_fire;

    assign exception    = e_valid[head] && e_ready[head] && e_exc[head];
    assign ex_pc        = e_pc[head];
    assign ex_vaddr     = e_vaddr[head];
    assign ex_rob_id    = head;
    assign alloc_ready  = (count < N_CNT) && !exception;
    assign alloc_rob_id = tail;
    assign alloc_fire   = alloc_valid && alloc_ready;

    assign bypass_s1       = e_value[rs1_rob_id];
    assign bypass_s2       = e_value[rs2_rob_id];
    assign bypass_s1_valid = e_valid[rs1_rob_id] && e_ready[rs1_rob_id] && !e_exc[rs1_rob_id];
    assign bypass_s2_valid = e_valid[rs2_rob_id] && e_ready[rs2_rob_id] && !e_exc[rs2_rob_id];

    // Retirement is in order: a slot may commit only if every older slot does; one store per cycle.
    always_comb begin
        logic ok;
        logic store_seen;
        ok              = 1'b1;
        store_seen      = 1'b0;
        n_commit        = '0;
        commit_valid    = '0;
        commit_is_store = '0;
        commit_rd       = '0;
        commit_value    = '0;
        commit_rob_id   = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            slot_id[s] = head + IW'(s);
            commit_rob_id[s*IW +: IW]                         = slot_id[s];
            commit_rd[s*REG_INDEX_SIZE +: REG_INDEX_SIZE]     = e_rd[slot_id[s]];
            commit_value[s*WORD_SIZE +: WORD_SIZE]            = e_value[slot_id[s]];
            commit_is_store[s]                                = e_store[slot_id[s]];
            ok = ok && e_valid[slot_id[s]] && e_ready[slot_id[s]] && !e_exc[slot_id[s]]
                 && (!e_store[slot_id[s]] || (sb_ready && !store_seen));
            commit_valid[s] = ok;
            store_seen      = store_seen || e_store[slot_id[s]];
            n_commit        = n_commit + (IW+1)'(ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || exception) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
            e_ready <= '0;
            e_exc   <= '0;
            e_store <= '0;
            for (int i = 0; i < N; i++) begin
                e_rd[i]    <= '0;
                e_value[i] <= '0;
                e_pc[i]    <= '0;
                e_vaddr[i] <= '0;
            end
        end else begin
            // Ascending port order lets the highest-index port win a same-ID collision.
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && e_valid[wb_rob_id[k*IW +: IW]]) begin
                    e_ready[wb_rob_id[k*IW +: IW]] <= 1'b1;
                    e_exc[wb_rob_id[k*IW +: IW]]   <= wb_exception[k];
                    e_value[wb_rob_id[k*IW +: IW]] <= wb_value[k*WORD_SIZE +: WORD_SIZE];
                    e_vaddr[wb_rob_id[k*IW +: IW]] <= wb_vaddr[k*WORD_SIZE +: WORD_SIZE];
                end
            end
            for (int s = 0; s < COMMIT_WIDTH; s++) begin
                if (commit_valid[s]) e_valid[slot_id[s]] <= 1'b0;
            end
            if (alloc_fire) begin
                e_valid[tail] <= 1'b1;
                e_ready[tail] <= alloc_exception;
                e_exc[tail]   <= alloc_exception;
                e_store[tail] <= alloc_is_store;
                e_rd[tail]    <= alloc_rd;
                e_value[tail] <= '0;
                e_pc[tail]    <= alloc_pc;
                e_vaddr[tail] <= alloc_exception ? alloc_pc : '0;
            end
            head  <= head + IW'(n_commit);
            tail  <= tail + IW'(alloc_fire);
            count <= count + (IW+1)'(alloc_fire) - n_commit;
        end
    end

endmodule

// File: doc/reorder_buffer_mc.md
REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

Interface
REQ-001 Parameter N, default 8: entry count, power of 2, >=4; ID width IW = clog2(N).
REQ-002 Parameter WORD_SIZE, default 32: data/address width.
REQ-003 Parameter REG_INDEX_SIZE, default 5: architectural register index width.
REQ-004 Parameter NUM_WB, default 3: writeback ports (ALU, MEM, MUL).
REQ-005 Parameter COMMIT_WIDTH, default 2, legal values 1 or 2: maximum retirements per cycle.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 alloc_valid/alloc_is_store/alloc_exception  in  1 each  decode allocation request, store flag, ITLB fault flag.
REQ-009 alloc_rd  in  REG_INDEX_SIZE; alloc_pc  in  WORD_SIZE  destination register and instruction PC.
REQ-010 alloc_ready  out  1  entry grantable this cycle; alloc_rob_id  out  IW  equals tail.
REQ-011 wb_valid/wb_exception  in  NUM_WB each; wb_rob_id  in  NUM_WB*IW; wb_value/wb_vaddr  in  NUM_WB*WORD_SIZE  packed writeback ports, port k at slice k.
REQ-012 rs1_rob_id/rs2_rob_id  in  IW; bypass_s1/bypass_s2  out  WORD_SIZE; bypass_s1_valid/bypass_s2_valid  out  1  operand forwarding.
REQ-013 commit_valid/commit_is_store  out  COMMIT_WIDTH; commit_rd  out  COMMIT_WIDTH*REG_INDEX_SIZE; commit_value  out  COMMIT_WIDTH*WORD_SIZE; commit_rob_id  out  COMMIT_WIDTH*IW  retirement slots, slot 0 oldest.
REQ-014 sb_ready  in  1  store buffer can accept a store permission this cycle.
REQ-015 exception  out  1; ex_pc/ex_vaddr  out  WORD_SIZE; ex_rob_id  out  IW  precise exception report.
REQ-016 count  out  IW+1  occupied entries.

Function
REQ-017 Per entry state SHALL be: valid, ready, exc, is_store, rd, value, pc, vaddr.
REQ-018 alloc_ready SHALL equal (count < N) && !exception; an entry freed by commit in a cycle SHALL NOT be reallocated in the same cycle.
REQ-019 An accepted allocation (alloc_valid && alloc_ready) SHALL write entry tail with valid=1, value=0, and tail SHALL advance modulo N.
REQ-020 If alloc_exception=1, the entry SHALL be written with ready=1, exc=1, vaddr=alloc_pc.
REQ-021 Writeback port k with wb_valid[k] SHALL set ready=1, value, exc=wb_exception[k], vaddr on entry wb_rob_id[k] when that entry is valid; writes to invalid entries SHALL be ignored.
REQ-022 Two ports targeting the same ID in one cycle: the highest-index port SHALL win.
REQ-023 Bypass outputs SHALL be combinational from registered state: bypass_sX_valid = valid && ready && !exc of the indexed entry; a writeback is visible one cycle later.
REQ-024 Slot 0 SHALL commit head when head is valid && ready && !exc && (!is_store || sb_ready).
REQ-025 Slot 1 (COMMIT_WIDTH=2) SHALL commit head+1 only if slot 0 commits and head+1 is valid && ready && !exc, and at most one of the two is a store.
REQ-026 Committed entries SHALL be invalidated at the edge; head SHALL advance by the number of commits, modulo N.
REQ-027 count SHALL update as count + accepted_alloc - commits each cycle.
REQ-028 exception SHALL be combinational 1 when head is valid && ready && exc; ex_pc, ex_vaddr and ex_rob_id SHALL come from head; commit_valid SHALL be all 0 that cycle.
REQ-029 At the edge with exception=1: all entries invalid, head=tail=0, count=0 (full flush); writebacks that cycle SHALL be discarded.
REQ-030 An excepting entry younger than head SHALL NOT assert exception; ordering is by ROB position only.
REQ-031 Outputs for non-committing slots SHALL be driven from their indexed entry but qualified only by commit_valid.

Reset
REQ-032 rst SHALL take precedence over all events: head=tail=count=0, all entry valid/ready/exc=0, values 0; outputs then count=0, alloc_ready=1, alloc_rob_id=0, commit_valid=0, exception=0.
REQ-033 rst asserted mid-operation SHALL discard in-flight allocations, writebacks and commits of that cycle.

Verification
REQ-034 N=8: allocate 8, no writebacks -> count=8, alloc_ready=0, ninth request ignored, alloc_rob_id=0.
REQ-035 Allocate IDs 0,1; wb ID1 then ID0 -> cycle after ID0 writes, both commit same cycle, slots 0/1 carry IDs 0/1, count=0.
REQ-036 Head is store, ready, sb_ready=0 for 3 cycles -> no commit for 3 cycles; sb_ready=1 -> commit_is_store[0]=1.
REQ-037 Allocate IDs 0-2; ID1 wb with exception vaddr 0x1000; then ID0 wb -> ID0 commits, next cycle exception=1, ex_rob_id=1, ex_vaddr=0x1000; following cycle count=0, head=tail=0.
REQ-038 Wrap-around: 12 alloc/commit pairs with N=8 -> alloc_rob_id sequence 0..7,0..3; no lost entries.
REQ-039 Ports 0 and 2 write ID3 simultaneously with 0xA and 0xB -> bypass of ID3 next cycle = 0xB.
